keypad_ebcd_scanner: RTL

- Scans the 4x4 calculator matrix keypad and debounces it.
- Encodes each accepted key press as the 5-bit eBCD word consumed by the calculator interface stage: bit 4 is the key strobe, bits 3:0 are the key code.
- Emits exactly one clean strobe pulse per debounced press. The code is stable before, during and after the strobe.

---
 rtl/keypad_ebcd_scanner.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_ebcd_scanner.sv
// 4x4 calculator keypad scanner/debouncer emitting one eBCD strobe per accepted press.
// Build with KEY_REPEAT_EN defined to add auto-repeat of digit keys 0-9 while held.
module keypad_ebcd_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int STROBE_CYC   = 4,
  parameter int REPEAT_DLY   = 5000000,
  parameter int REPEAT_PER   = 1000000
) (
  input  logic       sw_clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] eBCD,
  output logic       key_down
);

  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int ST_W = $clog2(STROBE_CYC + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || STROBE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1)
  begin : g_bad_cfg
    $error("keypad_ebcd_scanner: illegal parameter set");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, WAIT_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      rs_meta_q, rs_q;
  logic [3:0]      col_q, col_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      code_q, code_d;
  logic            strobe_q, strobe_d;
  logic            key_down_q, key_down_d;
  logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [ST_W-1:0] str_cnt_q, str_cnt_d;
`ifdef KEY_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HD_W   = $clog2(RP_MAX + 1);
  logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            rep_mode_q, rep_mode_d;
  logic [ST_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  function automatic logic [3:0] rotl(input logic [3:0] v);
    rotl = {v[2:0], v[3]};
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      default: low_idx = 2'd3;
    endcase
  endfunction

  // Calculator key layout: {row, col} -> eBCD code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    key_code = 4'h1;
      4'h1:    key_code = 4'h2;
      4'h2:    key_code = 4'h3;
      4'h3:    key_code = 4'hA;
      4'h4:    key_code = 4'h4;
      4'h5:    key_code = 4'h5;
      4'h6:    key_code = 4'h6;
      4'h7:    key_code = 4'hB;
      4'h8:    key_code = 4'h7;
      4'h9:    key_code = 4'h8;
      4'hA:    key_code = 4'h9;
      4'hB:    key_code = 4'hC;
      4'hC:    key_code = 4'hE;
      4'hD:    key_code = 4'h0;
      4'hE:    key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_d     = cand_q;
    code_d     = code_q;
    strobe_d   = strobe_q;
    key_down_d = key_down_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    str_cnt_d  = str_cnt_q;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          if (one_low(rs_q)) begin
            cand_d   = rs_q;
            db_cnt_d = '0;
            state_d  = DEBOUNCE;
          end else begin
            col_d = rotl(col_q);
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SC_W'(1);
        end
      end
      DEBOUNCE: begin
        if (rs_q == cand_q) begin
          if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
            code_d     = key_code(low_idx(cand_q), low_idx(col_q));
            key_down_d = 1'b1;
            str_cnt_d  = '0;
            db_cnt_d   = '0;
            state_d    = PRESS;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end else begin
          db_cnt_d = '0;
          col_d    = rotl(col_q);
          state_d  = SCAN;
        end
      end
      // First PRESS cycle keeps the strobe low so the code is set up ahead of it.
      PRESS: begin
        if (str_cnt_q == ST_W'(STROBE_CYC)) begin
          strobe_d = 1'b0;
          db_cnt_d = '0;
          state_d  = WAIT_RELEASE;
        end else begin
          strobe_d  = 1'b1;
          str_cnt_d = str_cnt_q + ST_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (rs_q == 4'b1111) begin
          if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
            db_cnt_d   = '0;
            key_down_d = 1'b0;
            strobe_d   = 1'b0;
            col_d      = rotl(col_q);
            state_d    = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end else begin
          db_cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
        col_d   = 4'b1110;
      end
    endcase
`ifdef KEY_REPEAT_EN
    hold_cnt_d = hold_cnt_q;
    rep_mode_d = rep_mode_q;
    rep_cnt_d  = rep_cnt_q;
    // Hold time is measured from the code load so repeats land at accept+DLY, +PER, ...
    if ((state_q == PRESS || state_q == WAIT_RELEASE) && rs_q == cand_q) begin
      hold_cnt_d = hold_cnt_q + HD_W'(1);
    end else begin
      hold_cnt_d = '0;
      rep_mode_d = 1'b0;
    end
    if (state_q == WAIT_RELEASE && state_d == WAIT_RELEASE) begin
      if (rep_cnt_q != '0) begin
        rep_cnt_d = rep_cnt_q - ST_W'(1);
      end else begin
        strobe_d = 1'b0;
      end
      if (rs_q == cand_q &&
          hold_cnt_q >= (rep_mode_q ? HD_W'(REPEAT_PER) : HD_W'(REPEAT_DLY))) begin
        hold_cnt_d = HD_W'(1);
        rep_mode_d = 1'b1;
        if (code_q <= 4'd9) begin
          strobe_d  = 1'b1;
          rep_cnt_d = ST_W'(STROBE_CYC - 1);
        end else begin
          rep_cnt_d = '0;
        end
      end else begin
        rep_mode_d = rep_mode_d;
      end
    end else begin
      rep_cnt_d = '0;
    end
`endif
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      rs_meta_q <= 4'b1111;
      rs_q      <= 4'b1111;
    end else begin
      rs_meta_q <= row;
      rs_q      <= rs_meta_q;
    end
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SCAN;
      col_q      <= 4'b1110;
      cand_q     <= 4'b1111;
      code_q     <= 4'h0;
      strobe_q   <= 1'b0;
      key_down_q <= 1'b0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      str_cnt_q  <= '0;
`ifdef KEY_REPEAT_EN
      hold_cnt_q <= '0;
      rep_mode_q <= 1'b0;
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      strobe_q   <= strobe_d;
      key_down_q <= key_down_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      str_cnt_q  <= str_cnt_d;
`ifdef KEY_REPEAT_EN
      hold_cnt_q <= hold_cnt_d;
      rep_mode_q <= rep_mode_d;
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign col      = col_q;
  assign eBCD     = {strobe_q, code_q};
  assign key_down = key_down_q;

endmodule
